// File: rtl/apb_arb_2m_if.sv
// APB bus bundle between the two-requester arbiter (master) and the slave fabric.
interface apb_arb_2m_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_arb_2m.sv
// Round-robin arbiter sharing one APB master port between two requesters; 3 cycles req-to-done
// with a zero-wait slave, +1 per pready=0 cycle; requesters hold req until doneN, optional access timeout.
module apb_arb_2m #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    apb_arb_2m_if.master      apb
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    // last_gnt doubles as the owner of the transfer in flight
    logic              last_q, last_d;

    logic              m0, m1, gnt0, gnt1;
    logic              fin, fin_err;
    logic [DATA_W-1:0] fin_rd;

    assign m0      = req0 & ~done0_q;
    assign m1      = req1 & ~done1_q;
    assign gnt0    = m0 & (~m1 | last_q);
    assign gnt1    = m1 & ~gnt0;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err0_d    = err0_q;
        err1_d    = err1_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_rd    = '0;

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (gnt0 || gnt1) begin
                    psel_d   = 1'b1;
                    pwrite_d = gnt0 ? wr0 : wr1;
                    paddr_d  = gnt0 ? addr0 : addr1;
                    if (gnt0) pwdata_d = wr0 ? wdata0 : '0;
                    else      pwdata_d = wr1 ? wdata1 : '0;
                    last_d   = gnt1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb.pready) begin
                    fin     = 1'b1;
                    fin_err = apb.pslverr;
                    fin_rd  = apb.prdata;
                end else if (TIMEOUT != 0 && cnt_inc == TO_VAL) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (fin) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            if (last_q) begin
                done1_d = 1'b1;
                err1_d  = fin_err;
                if (!pwrite_q) rdata1_d = fin_rd;
            end else begin
                done0_d = 1'b1;
                err0_d  = fin_err;
                if (!pwrite_q) rdata0_d = fin_rd;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
endmodule

// File: tb/tb_apb_arb_2m.sv
// Directed bench for apb_arb_2m: scoreboard of expected completions plus a reactive APB slave.
module tb_apb_arb_2m;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          pclk, prst;
    logic          req0, req1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          done0, done1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;

    apb_arb_2m_if #(.ADDR_W(AW), .DATA_W(DW)) apb();

    apb_arb_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .prst(prst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .apb(apb)
    );

    typedef struct {
        bit            id;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            err;
        logic [DW-1:0] rdata;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            passed = 0;
    int            ndone = 0;
    int            acc_run = 0;
    int            ws = 0;
    bit            never = 1'b0;
    bit            serr = 1'b0;
    logic [DW-1:0] rd_val = '0;
    logic [DW-1:0] exp_rd[2];

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input bit id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input bit er, input logic [DW-1:0] rd, input int acc);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = a; e.wdata = wd; e.err = er; e.rdata = rd; e.acc = acc;
        sb.push_back(e);
    endtask

    // One cycle: sample at negedge, score completions/bus, then drive the slave for the next edge.
    task automatic step();
        exp_t e;
        @(negedge pclk);
        if (prst) begin
            sb.delete();
            acc_run   = 0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            if (done0 || done1) begin
                ndone = ndone + 1;
                chk("done_exclusive", 64'(done0 & done1), 0);
                chk("done_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (!e.wr) exp_rd[e.id] = e.rdata;
                    chk("done_owner", 64'(done1), 64'(e.id));
                    chk("done_err", 64'(e.id ? err1 : err0), 64'(e.err));
                    chk("done_rdata", 64'(e.id ? rdata1 : rdata0), 64'(exp_rd[e.id]));
                    chk("access_cycles", 64'(acc_run), 64'(e.acc));
                end
            end
            if (apb.psel) begin
                chk("psel_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("paddr", 64'(apb.paddr), 64'(sb[0].addr));
                    chk("pwrite", 64'(apb.pwrite), 64'(sb[0].wr));
                    chk("pwdata", 64'(apb.pwdata), sb[0].wr ? 64'(sb[0].wdata) : 64'd0);
                end
                if (apb.penable) acc_run = acc_run + 1;
                else             acc_run = 0;
            end
        end
        if (!prst && apb.psel && apb.penable) begin
            if (!never && acc_run == ws + 1) begin
                apb.pready  = 1'b1;
                apb.pslverr = serr;
                apb.prdata  = rd_val;
            end else begin
                apb.pready  = 1'b0;
                apb.pslverr = 1'($urandom_range(0, 1));
                apb.prdata  = $urandom;
            end
        end else begin
            apb.pready  = 1'($urandom_range(0, 1));
            apb.pslverr = 1'($urandom_range(0, 1));
            apb.prdata  = $urandom;
        end
    endtask

    task automatic run_dones(input int n, input int budget);
        int target;
        target = ndone + n;
        for (int c = 0; c < budget && ndone < target; c++) step();
        chk("done_within_budget", 64'(ndone >= target), 1);
    endtask

    initial begin
        exp_rd[0] = '0; exp_rd[1] = '0;
        prst = 1'b1; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = '0;
        step(); step();
        chk("rst_psel", 64'(apb.psel), 0);
        chk("rst_penable", 64'(apb.penable), 0);
        chk("rst_paddr", 64'(apb.paddr), 0);
        chk("rst_done", 64'({done0, done1}), 0);
        chk("rst_err", 64'({err0, err1}), 0);
        chk("rst_rdata0", 64'(rdata0), 0);
        chk("rst_rdata1", 64'(rdata1), 0);
        prst = 1'b0;
        step();

        // Both requesters held from reset: 0,1,0,1 with one IDLE cycle between.
        ws = 0; rd_val = 32'h1234_5678;
        wr0 = 1'b0; addr0 = 32'h20;
        wr1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h77;
        push(0, 0, 32'h20, 0, 0, rd_val, 1);
        push(1, 1, 32'h30, 32'h77, 0, 0, 1);
        push(0, 0, 32'h20, 0, 0, rd_val, 1);
        push(1, 1, 32'h30, 32'h77, 0, 0, 1);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_dones(1, 50);
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                step();
                chk("gap_setup", 64'({apb.psel, apb.penable}), 64'(2'b10));
            end
        end
        step();

        // Single zero-wait write with exact cycle placement.
        wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hA5;
        push(0, 1, 32'h10, 32'hA5, 0, 0, 1);
        req0 = 1'b1;
        step();
        chk("wr_setup", 64'({apb.psel, apb.penable}), 64'(2'b10));
        step();
        chk("wr_access", 64'({apb.psel, apb.penable}), 64'(2'b11));
        step();
        chk("wr_done0", 64'(done0), 1);
        chk("wr_bus_idle", 64'({apb.psel, apb.penable}), 0);
        req0 = 1'b0;
        step();

        // Slave error on a write, held until the next clean completion clears it.
        serr = 1'b1; wr0 = 1'b1; addr0 = 32'h14; wdata0 = 32'h5;
        push(0, 1, 32'h14, 32'h5, 1, 0, 1);
        req0 = 1'b1;
        run_dones(1, 50);
        req0 = 1'b0;
        step();
        chk("err0_held", 64'(err0), 1);
        serr = 1'b0; wdata0 = 32'h6;
        push(0, 1, 32'h14, 32'h6, 0, 0, 1);
        req0 = 1'b1;
        run_dones(1, 50);
        req0 = 1'b0;
        step();

        // Read with 3 wait states from requester 1.
        ws = 3; rd_val = 32'hDEAD_BEEF;
        wr1 = 1'b0; addr1 = 32'h44;
        push(1, 0, 32'h44, 0, 0, 32'hDEAD_BEEF, 4);
        req1 = 1'b1;
        run_dones(1, 50);
        req1 = 1'b0;
        step();
        chk("rdata1_held", 64'(rdata1), 64'h0000_0000_DEAD_BEEF);

        // Access timeout on a read: error and zeroed read data.
        never = 1'b1; addr1 = 32'h80;
        push(1, 0, 32'h80, 0, 1, 0, TO);
        req1 = 1'b1;
        run_dones(1, 100);
        req1 = 1'b0;
        never = 1'b0; ws = 0;
        step();
        chk("to_bus_idle", 64'(apb.psel), 0);

        // Reset in the middle of an ACCESS phase.
        never = 1'b1; wr0 = 1'b1; addr0 = 32'h60; wdata0 = 32'h99;
        push(0, 1, 32'h60, 32'h99, 0, 0, 1);
        req0 = 1'b1;
        step(); step(); step();
        chk("pre_rst_access", 64'({apb.psel, apb.penable}), 64'(2'b11));
        prst = 1'b1; req0 = 1'b0;
        step();
        chk("mrst_psel", 64'(apb.psel), 0);
        chk("mrst_penable", 64'(apb.penable), 0);
        chk("mrst_pwrite", 64'(apb.pwrite), 0);
        chk("mrst_paddr", 64'(apb.paddr), 0);
        chk("mrst_pwdata", 64'(apb.pwdata), 0);
        chk("mrst_done", 64'({done0, done1}), 0);
        chk("mrst_err", 64'({err0, err1}), 0);
        chk("mrst_rdata0", 64'(rdata0), 0);
        chk("mrst_rdata1", 64'(rdata1), 0);
        never = 1'b0; ws = 0; rd_val = 32'h0BAD_CAFE;
        wr0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h11;
        wr1 = 1'b0; addr1 = 32'h50;
        push(0, 1, 32'h40, 32'h11, 0, 0, 1);
        push(1, 0, 32'h50, 0, 0, 32'h0BAD_CAFE, 1);
        req0 = 1'b1; req1 = 1'b1;
        prst = 1'b0;
        run_dones(2, 50);
        req0 = 1'b0; req1 = 1'b0;
        step(); step();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
